// File: rtl/xgmii_lb_switch.sv
// Per-channel XGMII crossbar (normal / near-end loop / far-end loop / isolate) that switches only between frames.
// Optional forced switch after SWITCH_TIMEOUT pending cycles is enabled by defining XGMII_LB_TIMEOUT_EN.
module xgmii_lb_switch #(
    parameter int LANES          = 4,
    parameter int DATA_W         = 64,
    parameter int SWITCH_TIMEOUT = 1024
) (
    input  logic                          clk_156,
    input  logic                          async_reset_n,
    input  logic [2*LANES-1:0]            mode_req,
    input  logic                          clear_err,
    input  logic [LANES*DATA_W-1:0]       mac_xgmii_txd,
    input  logic [LANES*(DATA_W/8)-1:0]   mac_xgmii_txc,
    input  logic [LANES*DATA_W-1:0]       pcs_xgmii_rxd,
    input  logic [LANES*(DATA_W/8)-1:0]   pcs_xgmii_rxc,
    output logic [LANES*DATA_W-1:0]       pcs_xgmii_txd,
    output logic [LANES*(DATA_W/8)-1:0]   pcs_xgmii_txc,
    output logic [LANES*DATA_W-1:0]       mac_xgmii_rxd,
    output logic [LANES*(DATA_W/8)-1:0]   mac_xgmii_rxc,
    output logic [2*LANES-1:0]            mode_act,
    output logic [LANES-1:0]              switch_pending,
    output logic [LANES-1:0]              timeout_err
);

    localparam int CTRL_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] IDLE_D = {CTRL_W{8'h07}};
    localparam logic [DATA_W-1:0] ERR_D  = {CTRL_W{8'hFE}};
    localparam logic [CTRL_W-1:0] CTRL_1 = {CTRL_W{1'b1}};

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

    function automatic logic is_start(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        logic s;
        s = 1'b0;
        for (int l = 0; l < CTRL_W; l++) begin
            if ((l == 0 || l == 4) && c[l] && d[l*8 +: 8] == 8'hFB) s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic is_term(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        logic t;
        t = 1'b0;
        for (int l = 0; l < CTRL_W; l++) begin
            if (c[l] && d[l*8 +: 8] == 8'hFD) t = 1'b1;
        end
        return t;
    endfunction

`ifdef XGMII_LB_TIMEOUT_EN
    localparam int CNT_W = $clog2(SWITCH_TIMEOUT + 1);
`else
    logic unused_cfg;
    assign unused_cfg = clear_err ^ (SWITCH_TIMEOUT > 0);
`endif

    for (genvar c = 0; c < LANES; c++) begin : g_ch
        logic [DATA_W-1:0] tx_d, rx_d;
        logic [CTRL_W-1:0] tx_c, rx_c;
        logic [1:0]        req;
        logic              tx_start, rx_start, boundary_ok, switch_now, forced, timeout_hit;

        state_e            state_q, state_d;
        logic [1:0]        mode_q, mode_d;
        logic              tx_inf_q, tx_inf_d, rx_inf_q, rx_inf_d;
        logic [DATA_W-1:0] ptx_dat_q, ptx_dat_d, mrx_dat_q, mrx_dat_d;
        logic [CTRL_W-1:0] ptx_ctl_q, ptx_ctl_d, mrx_ctl_q, mrx_ctl_d;

        assign tx_d = mac_xgmii_txd[c*DATA_W +: DATA_W];
        assign tx_c = mac_xgmii_txc[c*CTRL_W +: CTRL_W];
        assign rx_d = pcs_xgmii_rxd[c*DATA_W +: DATA_W];
        assign rx_c = pcs_xgmii_rxc[c*CTRL_W +: CTRL_W];
        assign req  = mode_req[2*c +: 2];

        assign tx_start = is_start(tx_d, tx_c);
        assign rx_start = is_start(rx_d, rx_c);
        // A start wins over a terminate in the same word: back-to-back frames keep the tracker set.
        assign tx_inf_d = tx_start ? 1'b1 : (is_term(tx_d, tx_c) ? 1'b0 : tx_inf_q);
        assign rx_inf_d = rx_start ? 1'b1 : (is_term(rx_d, rx_c) ? 1'b0 : rx_inf_q);
        assign boundary_ok = !tx_inf_q && !rx_inf_q && !tx_start && !rx_start;

`ifdef XGMII_LB_TIMEOUT_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             err_q, err_d;

        assign timeout_hit = (state_q == PEND) && (32'(cnt_q) + 32'd1 == 32'(SWITCH_TIMEOUT));
        assign cnt_d = (state_q == PEND && state_d == PEND) ? cnt_q + 1'b1 : '0;
        assign err_d = forced ? 1'b1 : (clear_err ? 1'b0 : err_q);

        always_ff @(posedge clk_156 or negedge async_reset_n) begin
            if (!async_reset_n) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                err_q <= err_d;
            end
        end
        assign timeout_err[c] = err_q;
`else
        assign timeout_hit    = 1'b0;
        assign timeout_err[c] = 1'b0;
`endif

        always_ff @(posedge clk_156 or negedge async_reset_n) begin
            if (!async_reset_n) begin
                state_q   <= RUN;
                mode_q    <= 2'd0;
                tx_inf_q  <= 1'b0;
                rx_inf_q  <= 1'b0;
                ptx_dat_q <= IDLE_D;
                ptx_ctl_q <= CTRL_1;
                mrx_dat_q <= IDLE_D;
                mrx_ctl_q <= CTRL_1;
            end else begin
                state_q   <= state_d;
                mode_q    <= mode_d;
                tx_inf_q  <= tx_inf_d;
                rx_inf_q  <= rx_inf_d;
                ptx_dat_q <= ptx_dat_d;
                ptx_ctl_q <= ptx_ctl_d;
                mrx_dat_q <= mrx_dat_d;
                mrx_ctl_q <= mrx_ctl_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            switch_now = 1'b0;
            forced     = 1'b0;
            case (state_q)
                RUN: begin
                    if (req != mode_q) begin
                        if (boundary_ok) switch_now = 1'b1;
                        else             state_d    = PEND;
                    end
                end
                PEND: begin
                    if (req == mode_q) begin
                        state_d = RUN;
                    end else if (boundary_ok) begin
                        switch_now = 1'b1;
                        state_d    = RUN;
                    end else if (timeout_hit) begin
                        switch_now = 1'b1;
                        forced     = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
            mode_d = switch_now ? req : mode_q;
        end

        // Routing uses mode_d so the word sampled on a switching edge already follows the new mode.
        always_comb begin
            ptx_dat_d = IDLE_D;
            ptx_ctl_d = CTRL_1;
            mrx_dat_d = IDLE_D;
            mrx_ctl_d = CTRL_1;
            case (mode_d)
                2'd0: begin
                    ptx_dat_d = tx_d;
                    ptx_ctl_d = tx_c;
                    mrx_dat_d = rx_d;
                    mrx_ctl_d = rx_c;
                end
                2'd1: begin
                    mrx_dat_d = tx_d;
                    mrx_ctl_d = tx_c;
                end
                2'd2: begin
                    ptx_dat_d = rx_d;
                    ptx_ctl_d = rx_c;
                end
                default: ;
            endcase
            if (forced) begin
                if ((mode_q == 2'd0 && tx_inf_q) || (mode_q == 2'd2 && rx_inf_q)) begin
                    ptx_dat_d = ERR_D;
                    ptx_ctl_d = CTRL_1;
                end
                if ((mode_q == 2'd0 && rx_inf_q) || (mode_q == 2'd1 && tx_inf_q)) begin
                    mrx_dat_d = ERR_D;
                    mrx_ctl_d = CTRL_1;
                end
            end
        end

        always_comb begin
            switch_pending[c] = (state_q == PEND);
            mode_act[2*c +: 2] = mode_q;
        end

        assign pcs_xgmii_txd[c*DATA_W +: DATA_W] = ptx_dat_q;
        assign pcs_xgmii_txc[c*CTRL_W +: CTRL_W] = ptx_ctl_q;
        assign mac_xgmii_rxd[c*DATA_W +: DATA_W] = mrx_dat_q;
        assign mac_xgmii_rxc[c*CTRL_W +: CTRL_W] = mrx_ctl_q;
    end

endmodule

// File: tb/tb_xgmii_lb_switch.sv
// Directed bench for xgmii_lb_switch: routing per mode, frame-boundary switching and reset behaviour.
module tb_xgmii_lb_switch;
    localparam int LANES = 4;
    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
    localparam logic [71:0] F0     = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] F1     = {8'h00, 64'h0123456789ABCDEF};
    localparam logic [71:0] F2     = {8'h00, 64'hFEDCBA9876543210};
    localparam logic [71:0] F3     = {8'hFF, 64'h07070707070707FD};
    localparam logic [71:0] BB     = {8'h1E, 64'h555555FB0707FD11};

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [2*LANES-1:0]    mode_req = '0;
    logic                  clear_err = 1'b0;
    logic [LANES*DW-1:0]   mac_txd, pcs_rxd, pcs_txd, mac_rxd;
    logic [LANES*CW-1:0]   mac_txc, pcs_rxc, pcs_txc, mac_rxc;
    logic [2*LANES-1:0]    mode_act;
    logic [LANES-1:0]      pending, terr;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    xgmii_lb_switch #(.LANES(LANES), .DATA_W(DW), .SWITCH_TIMEOUT(16)) dut (
        .clk_156(clk), .async_reset_n(rst_n), .mode_req(mode_req), .clear_err(clear_err),
        .mac_xgmii_txd(mac_txd), .mac_xgmii_txc(mac_txc),
        .pcs_xgmii_rxd(pcs_rxd), .pcs_xgmii_rxc(pcs_rxc),
        .pcs_xgmii_txd(pcs_txd), .pcs_xgmii_txc(pcs_txc),
        .mac_xgmii_rxd(mac_rxd), .mac_xgmii_rxc(mac_rxc),
        .mode_act(mode_act), .switch_pending(pending), .timeout_err(terr)
    );

    function automatic logic [71:0] ptx(input int ch);
        return {pcs_txc[ch*CW +: CW], pcs_txd[ch*DW +: DW]};
    endfunction
    function automatic logic [71:0] mrx(input int ch);
        return {mac_rxc[ch*CW +: CW], mac_rxd[ch*DW +: DW]};
    endfunction
    function automatic logic [1:0] mact(input int ch);
        return mode_act[ch*2 +: 2];
    endfunction
    function automatic logic [71:0] rxw(input int i);
        if (i == 0) return F0;
        if (i == 7) return F3;
        return {8'h00, 64'(i) * 64'h0101010101010101};
    endfunction

    task automatic set_tx(input int ch, input logic [71:0] w);
        mac_txd[ch*DW +: DW] = w[63:0];
        mac_txc[ch*CW +: CW] = w[71:64];
    endtask
    task automatic set_rx(input int ch, input logic [71:0] w);
        pcs_rxd[ch*DW +: DW] = w[63:0];
        pcs_rxc[ch*CW +: CW] = w[71:64];
    endtask
    task automatic set_mode(input int ch, input logic [1:0] m);
        mode_req[ch*2 +: 2] = m;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int ch = 0; ch < LANES; ch++) begin
            set_tx(ch, IDLE_W);
            set_rx(ch, IDLE_W);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int ch = 0; ch < LANES; ch++) begin
            nchk++;
            if (ptx(ch) !== IDLE_W || mrx(ch) !== IDLE_W) begin
                nerr++;
                $display("FAIL rst_idle ch%0d ptx=%h mrx=%h exp %h", ch, ptx(ch), mrx(ch), IDLE_W);
            end
        end
        nchk++;
        if (mode_act !== '0 || pending !== '0 || terr !== '0) begin
            nerr++;
            $display("FAIL rst_ctrl mode_act=%h pend=%h err=%h exp 0", mode_act, pending, terr);
        end
        step();
        step();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_normal();
        logic [71:0] tx [4];
        logic [71:0] rw;
        tx[0] = F0; tx[1] = F1; tx[2] = F2; tx[3] = F3;
        for (int i = 0; i < 4; i++) begin
            rw = {8'h00, 64'hA5A5A5A5A5A5A500 | 64'(i)};
            set_tx(0, tx[i]);
            set_rx(0, rw);
            step();
            nchk++;
            if (ptx(0) !== tx[i]) begin
                nerr++; $display("FAIL nrm_ptx0 w%0d got %h exp %h", i, ptx(0), tx[i]);
            end
            nchk++;
            if (mrx(0) !== rw) begin
                nerr++; $display("FAIL nrm_mrx0 w%0d got %h exp %h", i, mrx(0), rw);
            end
            nchk++;
            if (ptx(1) !== IDLE_W || mrx(3) !== IDLE_W) begin
                nerr++; $display("FAIL nrm_other w%0d ptx1=%h mrx3=%h exp %h", i, ptx(1), mrx(3), IDLE_W);
            end
        end
        set_tx(0, IDLE_W);
        set_rx(0, IDLE_W);
        step();
    endtask

    task automatic test_near_loop();
        logic [71:0] tx [4];
        tx[0] = F0; tx[1] = F1; tx[2] = F2; tx[3] = F3;
        set_mode(1, 2'd1);
        step();
        nchk++;
        if (mact(1) !== 2'd1 || pending[1] !== 1'b0) begin
            nerr++; $display("FAIL near_switch mode=%0d pend=%b exp 1/0", mact(1), pending[1]);
        end
        for (int i = 0; i < 4; i++) begin
            set_tx(1, tx[i]);
            step();
            nchk++;
            if (mrx(1) !== tx[i]) begin
                nerr++; $display("FAIL near_mrx1 w%0d got %h exp %h", i, mrx(1), tx[i]);
            end
            nchk++;
            if (ptx(1) !== IDLE_W) begin
                nerr++; $display("FAIL near_ptx1 w%0d got %h exp %h", i, ptx(1), IDLE_W);
            end
        end
        set_tx(1, IDLE_W);
        set_mode(1, 2'd0);
        step();
        nchk++;
        if (mact(1) !== 2'd0) begin
            nerr++; $display("FAIL near_back mode=%0d exp 0", mact(1));
        end
    endtask

    task automatic test_far_pending();
        logic [71:0] w;
        for (int i = 0; i < 8; i++) begin
            set_rx(2, rxw(i));
            if (i == 2) set_mode(2, 2'd2);
            step();
            nchk++;
            if (pending[2] !== (i >= 2) || mact(2) !== 2'd0) begin
                nerr++; $display("FAIL far_pend w%0d pend=%b mode=%0d exp %b/0", i, pending[2], mact(2), i >= 2);
            end
            nchk++;
            if (ptx(2) !== IDLE_W || mrx(2) !== rxw(i)) begin
                nerr++; $display("FAIL far_route w%0d ptx=%h mrx=%h exp %h/%h", i, ptx(2), mrx(2), IDLE_W, rxw(i));
            end
        end
        set_rx(2, IDLE_W);
        step();
        nchk++;
        if (mact(2) !== 2'd2 || pending[2] !== 1'b0) begin
            nerr++; $display("FAIL far_switch mode=%0d pend=%b exp 2/0", mact(2), pending[2]);
        end
        nchk++;
        if (mrx(2) !== IDLE_W || ptx(2) !== IDLE_W) begin
            nerr++; $display("FAIL far_idle mrx=%h ptx=%h exp %h", mrx(2), ptx(2), IDLE_W);
        end
        w = {8'h00, 64'h0F0E0D0C0B0A0908};
        set_rx(2, w);
        step();
        nchk++;
        if (ptx(2) !== w) begin
            nerr++; $display("FAIL far_loop got %h exp %h", ptx(2), w);
        end
        set_rx(2, IDLE_W);
        set_mode(2, 2'd0);
        step();
        nchk++;
        if (mact(2) !== 2'd0) begin
            nerr++; $display("FAIL far_back mode=%0d exp 0", mact(2));
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] seq [5];
        logic        pexp [5];
        seq[0] = F1; seq[1] = BB; seq[2] = IDLE_W; seq[3] = F3; seq[4] = IDLE_W;
        pexp[0] = 1; pexp[1] = 1; pexp[2] = 1; pexp[3] = 1; pexp[4] = 0;
        set_tx(3, F0);
        step();
        set_mode(3, 2'd3);
        for (int i = 0; i < 5; i++) begin
            set_tx(3, seq[i]);
            step();
            nchk++;
            if (pending[3] !== pexp[i] || mact(3) !== (pexp[i] ? 2'd0 : 2'd3)) begin
                nerr++; $display("FAIL b2b_pend w%0d pend=%b mode=%0d exp %b/%0d", i, pending[3], mact(3), pexp[i], pexp[i] ? 0 : 3);
            end
            nchk++;
            if (ptx(3) !== (pexp[i] ? seq[i] : IDLE_W)) begin
                nerr++; $display("FAIL b2b_ptx w%0d got %h", i, ptx(3));
            end
        end
        set_mode(3, 2'd0);
        step();
        nchk++;
        if (mact(3) !== 2'd0) begin
            nerr++; $display("FAIL b2b_back mode=%0d exp 0", mact(3));
        end
    endtask

`ifdef XGMII_LB_TIMEOUT_EN
    task automatic test_timeout();
        set_tx(0, F0);
        step();
        set_tx(0, F1);
        set_mode(0, 2'd3);
        step();
        for (int k = 0; k < 16; k++) begin
            nchk++;
            if (pending[0] !== 1'b1 || mact(0) !== 2'd0) begin
                nerr++; $display("FAIL to_pend c%0d pend=%b mode=%0d exp 1/0", k, pending[0], mact(0));
            end
            step();
        end
        nchk++;
        if (mact(0) !== 2'd3 || pending[0] !== 1'b0 || terr[0] !== 1'b1) begin
            nerr++; $display("FAIL to_force mode=%0d pend=%b err=%b exp 3/0/1", mact(0), pending[0], terr[0]);
        end
        nchk++;
        if (ptx(0) !== ERR_W || mrx(0) !== IDLE_W) begin
            nerr++; $display("FAIL to_errword ptx=%h mrx=%h exp %h/%h", ptx(0), mrx(0), ERR_W, IDLE_W);
        end
        step();
        nchk++;
        if (ptx(0) !== IDLE_W || terr[0] !== 1'b1) begin
            nerr++; $display("FAIL to_after ptx=%h err=%b exp %h/1", ptx(0), terr[0], IDLE_W);
        end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        nchk++;
        if (terr[0] !== 1'b0) begin
            nerr++; $display("FAIL to_clear err=%b exp 0", terr[0]);
        end
        set_tx(0, F3);
        step();
        set_tx(0, IDLE_W);
        set_mode(0, 2'd0);
        step();
        nchk++;
        if (mact(0) !== 2'd0) begin
            nerr++; $display("FAIL to_back mode=%0d exp 0", mact(0));
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [71:0] w;
        w = {8'h00, 64'hC0FFEE0012345678};
        set_mode(1, 2'd1);
        step();
        set_tx(1, F0);
        step();
        nchk++;
        if (mrx(1) !== F0) begin
            nerr++; $display("FAIL rm_loop got %h exp %h", mrx(1), F0);
        end
        set_tx(1, F1);
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if (mrx(1) !== IDLE_W || ptx(1) !== IDLE_W || mode_act !== '0) begin
            nerr++; $display("FAIL rm_async mrx=%h ptx=%h mode_act=%h exp idle/0", mrx(1), ptx(1), mode_act);
        end
        set_mode(1, 2'd0);
        set_tx(1, w);
        step();
        #2 rst_n = 1'b1;
        step();
        nchk++;
        if (ptx(1) !== w || mrx(1) !== IDLE_W || mact(1) !== 2'd0) begin
            nerr++; $display("FAIL rm_resume ptx=%h mrx=%h mode=%0d exp %h/%h/0", ptx(1), mrx(1), mact(1), w, IDLE_W);
        end
        set_tx(1, IDLE_W);
        set_mode(1, 2'd1);
        step();
        nchk++;
        if (mact(1) !== 2'd1 || pending[1] !== 1'b0) begin
            nerr++; $display("FAIL rm_trkclr mode=%0d pend=%b exp 1/0", mact(1), pending[1]);
        end
        set_mode(1, 2'd0);
        step();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_near_loop();
        test_far_pending();
        test_back_to_back();
`ifdef XGMII_LB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
